rx_buffer_regs: RTL

Receive buffer and status register block, directly downstream of the protocol-layer receive state machine.
- Captures the byte stream that stage writes (address, data, strobe) into a DEPTH-byte message buffer.
- Maintains RECEIVE_BYTE_COUNT, RX_BUF_FRAME_TYPE and the ALERT bits 2 (RX status) and 10 (RX buffer overflow).
- Holds a completed message until the TCPM reads it and releases it with a write-1-to-clear of ALERT[2].

---
 rtl/rx_buffer_regs.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rx_buffer_regs.sv
// rx_buffer_regs - receive message buffer and RX status registers.
//
// The protocol-layer receive stage writes a message byte by byte (address,
// data, strobe) and then pulses iMSG_END. The block holds the message in a
// DEPTH-byte buffer, reports it through RECEIVE_BYTE_COUNT, RX_BUF_FRAME_TYPE
// and ALERT[2], and keeps it until the TCPM releases it by writing 1 to
// ALERT[2]. Any write that cannot be stored raises ALERT[10] when it is an
// overflow or a write into a held message.
//
// Optional feature: define RX_BUF_DROP_CNT_EN to add oDROP_CNT, a saturating
// count of dropped writes that is cleared together with ALERT[10].

module rx_buffer_regs #(
  parameter int          DEPTH     = 31,
  parameter logic [7:0]  BASE_ADDR = 8'h31
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        iWR_EN,
  input  logic [7:0]  iDIR_WRITE,
  input  logic [7:0]  iDATA_to_Buffer,
  input  logic        iMSG_END,
  input  logic        iRD_EN,
  input  logic [4:0]  iRD_ADDR,
  input  logic [15:0] iALERT_CLEAR,
  output logic [7:0]  oRD_DATA,
  output logic        oRD_VALID,
  output logic [7:0]  oRECEIVE_BYTE_COUNT,
  output logic [7:0]  oRX_BUF_FRAME_TYPE,
  output logic [15:0] oALERT,
  output logic        oBUF_FULL
`ifdef RX_BUF_DROP_CNT_EN
  ,
  output logic [7:0]  oDROP_CNT
`endif
);

  // Count must reach DEPTH itself; the buffer index only needs 0..DEPTH-1.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_OVF   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_alert_rx;
  logic          r_alert_ovf;
  logic [7:0]    r_frame_type;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;

  // Sized to a power of two so any 5-bit read index stays inside the array;
  // entries at or above the count are masked on read.
  logic [7:0]    r_mem [0:(1<<AW)-1];

  logic [7:0]    w_idx;
  logic          w_held;
  logic          w_accept;
  logic          w_drop;
  logic          w_ovf_set;
  logic          w_msg_end;
  logic          w_release;
  logic          w_rd_hit;

  assign w_idx    = iDIR_WRITE - BASE_ADDR;
  assign w_held   = (r_state == ST_READY) || (r_state == ST_OVF);
  assign w_rd_hit = 8'(iRD_ADDR) < 8'(r_count);

  // Classify the incoming write and the message-end / release events.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_accept  = 1'b0;
    w_drop    = 1'b0;
    w_ovf_set = 1'b0;
    if (iWR_EN) begin
      if (w_held) begin
        w_drop    = 1'b1;
        w_ovf_set = 1'b1;
      end else if ((r_state == ST_FILL) && (r_count == CW'(DEPTH))) begin
        w_drop    = 1'b1;
        w_ovf_set = 1'b1;
      end else if (w_idx == 8'(r_count)) begin
        w_accept  = 1'b1;
      end else begin
        w_drop    = 1'b1;
      end
    end
    // An overflowing write takes precedence over a simultaneous message end.
    w_msg_end = iMSG_END && (r_state == ST_FILL) && !w_ovf_set;
    w_release = iALERT_CLEAR[2] && w_held;
  end

  // Buffer storage: written only by accepted bytes, at the current count.
  always_ff @(posedge CLK) begin
    // NOTE: the buffer has no reset; count=0 makes stale contents unreadable,
    // and leaving it out lets the array map onto plain RAM.
    if (!reset && w_accept) begin
      r_mem[r_count[AW-1:0]] <= iDATA_to_Buffer;
    end
  end

  // Control state, byte count, frame type and alert bits.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_count      <= '0;
      r_frame_type <= 8'h00;
      r_alert_rx   <= 1'b0;
      r_alert_ovf  <= 1'b0;
    end else begin
      if (w_release) begin
        r_state      <= ST_EMPTY;
        r_count      <= '0;
        r_frame_type <= 8'h00;
      end else if (w_accept) begin
        r_count <= r_count + CW'(1);
        if (r_count == '0) begin
          r_frame_type <= iDATA_to_Buffer;
        end
        // The byte arriving with the message-end pulse is counted first.
        r_state <= w_msg_end ? ST_READY : ST_FILL;
      end else if (w_msg_end) begin
        r_state <= ST_READY;
      end else if (w_ovf_set && (r_state == ST_FILL)) begin
        r_state <= ST_OVF;
      end

      // Set beats clear when both hit the same bit in one cycle.
      if (w_msg_end) begin
        r_alert_rx <= 1'b1;
      end else if (iALERT_CLEAR[2]) begin
        r_alert_rx <= 1'b0;
      end

      if (w_ovf_set) begin
        r_alert_ovf <= 1'b1;
      end else if (iALERT_CLEAR[10]) begin
        r_alert_ovf <= 1'b0;
      end
    end
  end

  // TCPM read port: one-cycle latency, bytes beyond the count read as zero.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= iRD_EN;
      if (iRD_EN) begin
        r_rd_data <= w_rd_hit ? r_mem[iRD_ADDR[AW-1:0]] : 8'h00;
      end
    end
  end

`ifdef RX_BUF_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating dropped-write counter; a drop during the clear leaves it at 1.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_drop_cnt <= 8'h00;
    end else if (iALERT_CLEAR[10]) begin
      r_drop_cnt <= w_drop ? 8'h01 : 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign oDROP_CNT = r_drop_cnt;
`else
  // Without the counter the drop classification has no consumer.
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

  // Clear-mask bits with no alert behind them are ignored.
  logic w_clear_unused;
  assign w_clear_unused = &{iALERT_CLEAR[15:11], iALERT_CLEAR[9:3], iALERT_CLEAR[1:0]};

  assign oRD_DATA            = r_rd_data;
  assign oRD_VALID           = r_rd_valid;
  assign oRECEIVE_BYTE_COUNT = 8'(r_count);
  assign oRX_BUF_FRAME_TYPE  = r_frame_type;
  assign oALERT              = {5'b0, r_alert_ovf, 7'b0, r_alert_rx, 2'b0};
  assign oBUF_FULL           = w_held;

endmodule
